axis_demux: RTL
===============

# axis_demux

Single-clock AXI-Stream packet demultiplexer: one slave stream fans out to NUM_SINKS master streams, with a destination index taken from the first beat's `s_tuser`. Routing is decided once per packet and held until `tlast`. Each sink has a small first-word-fall-through FIFO. It is the receive-side counterpart of the N-to-1 stream mux and sits between a shared link and per-consumer pipelines. Packets addressed to a non-existent sink are consumed, discarded and counted.

## Interface
- FIFO_DEPTH, 8: entries per sink FIFO, power of two, ≥2.
- DATA_WIDTH, 32: tdata width.
- USER_WIDTH, 8: tuser width, passed through unchanged.
- NUM_SINKS, 2: number of outputs, 2..8; values above 8 are an elaboration error.
- DEST_LSB, 0: LSB of the destination field within tuser. The field is DEST_W = max(1, clog2(NUM_SINKS)) bits wide. DEST_LSB + DEST_W must not exceed USER_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat ready.
- s_tlast  in  1  last beat of packet.
- s_tuser  in  USER_WIDTH  user bits; destination field read on the head beat only.
- s_tdata  in  DATA_WIDTH  payload.
- m_tvalid  out  NUM_SINKS  per-sink valid.
- m_tready  in  NUM_SINKS  per-sink ready.
- m_tlast  out  NUM_SINKS  per-sink last.
- m_tuser  out  USER_WIDTH*NUM_SINKS  sink i occupies bits [(i+1)*USER_WIDTH-1 : i*USER_WIDTH].
- m_tdata  out  DATA_WIDTH*NUM_SINKS  packed the same way as m_tuser.
- dropCount  out  16  number of dropped packets, saturating.

## Operation
- Beat acceptance: `s_tvalid && s_tready`.
- `headDest` = s_tuser[DEST_LSB +: DEST_W]. `curDest` is a register latched from headDest.
- FSM states:
  - HEAD:
    - Accepted beat with headDest < NUM_SINKS: the beat is written to FIFO[headDest] and curDest ← headDest. If !tlast, go to BODY. If tlast, stay in HEAD (single-beat packet).
    - Accepted beat with headDest ≥ NUM_SINKS: the beat is discarded and dropCount increments. If !tlast, go to DROP.
  - BODY: the beat is written to FIFO[curDest]. tlast returns to HEAD. tuser is not re-examined.
  - DROP: the beat is discarded. tlast returns to HEAD.
- s_tready:
  - 0 while rst is high.
  - HEAD: !full[headDest] if headDest is valid, else 1.
  - BODY: !full[curDest].
  - DROP: 1.
  - s_tready never depends on m_tready.
- FIFO entry is {tlast, tuser, tdata}.
- Sink outputs:
  - m_tvalid[i] = !empty[i].
  - m_* for sink i come from the head of FIFO i.
  - Pop on `m_tvalid[i] && m_tready[i]`.
- Head-of-line blocking is intended: if the current destination's FIFO is full, all input stalls.
- dropCount saturates at 16'hFFFF.

## Timing
- Reset (rst high at an edge):
  - FSM → HEAD.
  - All FIFOs are emptied, so m_tvalid = 0.
  - dropCount = 0.
  - m_tlast, m_tuser and m_tdata = 0 while the FIFO is empty.
- Latency: a beat accepted at edge k gives m_tvalid high in the cycle following edge k. This is one cycle, through the FIFO write.
- Throughput: one beat per clock when the destination FIFO is not full and the sink keeps m_tready high.
- Full FIFO:
  - A write is blocked when full, even if a pop happens in the same cycle. The slot frees one cycle later.
  - Sustained rate with m_tready = 1 is still 1 beat/clk, because the FIFO never fills in that case.
- Simultaneous write and read on the same non-full, non-empty FIFO: both occur, and the count is unchanged.
- Empty FIFO: a write is visible at the output the next cycle (no same-cycle bypass).
- m_* stay stable while m_tvalid && !m_tready.
- Reset mid-packet: the partial packet held in FIFOs is lost. Sinks see no further beats of it. The next accepted beat is treated as a head.
- Back-to-back packets: the head beat immediately after a tlast is routed by its own tuser with no bubble.

## Structure
- The package `axis_demux_pkg` holds:
  - the function computing DEST_W;
  - the FIFO entry field offsets: LAST_BIT = DATA_WIDTH+USER_WIDTH, USER_LSB = DATA_WIDTH;
  - the FSM state encoding: HEAD, BODY, DROP.
- One sub-module, `axis_fifo_sc`:
  - single-clock FWFT FIFO;
  - parameters aw, dw;
  - ports: clk, rst, din, we, full, dout, re, empty.
  - It is instantiated NUM_SINKS times in a generate loop.

## Test plan
- Routing: 4-beat packet, tuser = 1, NUM_SINKS = 2. Data 0xA0..0xA3 appear only on sink 1 starting 1 cycle after the first accept. tlast on 0xA3. Sink 0 m_tvalid stays 0.
- Mid-packet tuser change: tuser = 0 on the head beat, then tuser = 1 on beats 2–3. The whole packet goes to sink 0, and the tuser values are passed through unchanged.
- Drop: NUM_SINKS = 3, head tuser = 3, 5-beat packet. s_tready = 1 on every beat, no m_tvalid anywhere, dropCount = 1. The next packet to sink 2 is delivered intact.
- Backpressure: m_tready[0] = 0 with a 12-beat packet to sink 0, FIFO_DEPTH = 8.
  - s_tready drops after 8 accepts.
  - Raising m_tready resumes flow.
  - All 12 beats are delivered in order with no duplicates.
- Head-of-line blocking: sink 0 is full and stalled. A following packet to sink 1 is not accepted until sink 0 drains one entry.
- Reset mid-packet: assert rst for 1 cycle after 2 of 4 beats.
  - During rst: m_tvalid = 0, s_tready = 0, dropCount = 0.
  - The next single-beat packet with tlast = 1 and tuser = 0 is delivered to sink 0 one cycle after acceptance.

Source files
------------

// File: rtl/axis_demux_pkg.sv
// axis_demux_pkg: shared definitions for the AXI-Stream packet demultiplexer.
//   - dest_width(): width of the destination field carried in tuser
//   - last_bit()/user_lsb(): field offsets inside a sink FIFO entry {tlast, tuser, tdata}
//   - state_t: routing FSM encoding (HEAD / BODY / DROP)
package axis_demux_pkg;

   typedef enum logic [1:0] {
      HEAD = 2'd0,   // waiting for / routing the first beat of a packet
      BODY = 2'd1,   // forwarding the rest of a packet to the latched sink
      DROP = 2'd2    // swallowing the rest of a packet with an invalid destination
   } state_t;

   // Destination field width: enough bits to index every sink, never zero.
   function automatic int dest_width(input int num_sinks);
      int w;
      w = $clog2(num_sinks);
      return (w < 1) ? 1 : w;
   endfunction

   // Bit position of tlast in a FIFO entry.
   function automatic int last_bit(input int data_width, input int user_width);
      return data_width + user_width;
   endfunction

   // LSB of the tuser field in a FIFO entry.
   function automatic int user_lsb(input int data_width);
      return data_width;
   endfunction

endpackage

// File: rtl/axis_demux_fifo.sv
// axis_fifo_sc: single-clock first-word-fall-through FIFO, 2**aw entries of dw bits.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   din, we      write data / write request (ignored while full, even if popping)
//   full         no free entry
//   dout, re     head entry (zero while empty) / pop request (ignored while empty)
//   empty        no valid entry
module axis_fifo_sc
   import axis_demux_pkg::*;
#(
   parameter int aw = 3,
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [dw-1:0] din,
   input  logic          we,
   output logic          full,
   output logic [dw-1:0] dout,
   input  logic          re,
   output logic          empty
);

   localparam int DEPTH = 1 << aw;

   logic [dw-1:0] mem_r [DEPTH];
   logic [aw-1:0] wr_ptr_r;
   logic [aw-1:0] rd_ptr_r;
   logic [aw:0]   count_r;
   logic          push_s;
   logic          pop_s;

   assign full   = (count_r == (aw+1)'(DEPTH));
   assign empty  = (count_r == {(aw+1){1'b0}});
   // Full is judged on the registered count, so a same-cycle pop does not free a slot.
   assign push_s = we && !full;
   assign pop_s  = re && !empty;

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {aw{1'b0}};
         rd_ptr_r <= {aw{1'b0}};
         count_r  <= {(aw+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + aw'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + aw'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (aw+1)'(1);
            2'b01:   count_r <= count_r - (aw+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head entry presented straight from storage; forced to zero while empty.
   always_comb begin
      if (empty) begin
         dout = {dw{1'b0}};
      end else begin
         dout = mem_r[rd_ptr_r];
      end
   end

endmodule

// File: rtl/axis_demux.sv
// axis_demux: AXI-Stream 1-to-NUM_SINKS packet demultiplexer.
// The destination is read from s_tuser[DEST_LSB +: DEST_W] on the head beat and
// held until tlast; packets to a non-existent sink are consumed and counted.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tlast/
//   s_tuser/s_tdata                   slave stream
//   m_tvalid/m_tready/m_tlast         per-sink handshake, bit i = sink i
//   m_tuser/m_tdata                   per-sink payload, sink i in slice i
//   dropCount                         saturating count of dropped packets
module axis_demux
   import axis_demux_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 8,
   parameter int NUM_SINKS  = 2,
   parameter int DEST_LSB   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_tvalid,
   output logic                             s_tready,
   input  logic                             s_tlast,
   input  logic [USER_WIDTH-1:0]            s_tuser,
   input  logic [DATA_WIDTH-1:0]            s_tdata,
   output logic [NUM_SINKS-1:0]             m_tvalid,
   input  logic [NUM_SINKS-1:0]             m_tready,
   output logic [NUM_SINKS-1:0]             m_tlast,
   output logic [USER_WIDTH*NUM_SINKS-1:0]  m_tuser,
   output logic [DATA_WIDTH*NUM_SINKS-1:0]  m_tdata,
   output logic [15:0]                      dropCount
);

   localparam int DEST_W   = dest_width(NUM_SINKS);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W  = DATA_WIDTH + USER_WIDTH + 1;
   localparam int LAST_BIT = last_bit(DATA_WIDTH, USER_WIDTH);
   localparam int USER_LSB = user_lsb(DATA_WIDTH);
   localparam logic [DEST_W:0] SINKS_V = (DEST_W+1)'(NUM_SINKS);

   if (NUM_SINKS < 2 || NUM_SINKS > 8) begin : g_bad_sinks
      $error("axis_demux: NUM_SINKS must be in 2..8");
   end
   if (DEST_LSB + DEST_W > USER_WIDTH) begin : g_bad_dest
      $error("axis_demux: destination field exceeds USER_WIDTH");
   end
   if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
      $error("axis_demux: FIFO_DEPTH must be a power of two >= 2");
   end

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [DEST_W-1:0]      head_dest_s;
   logic [DEST_W-1:0]      cur_dest_r;
   logic [DEST_W-1:0]      sel_dest_s;
   logic                   head_ok_s;
   logic                   sel_full_s;
   logic                   ready_s;
   logic                   accept_s;
   logic                   keep_s;
   logic                   drop_s;
   logic [15:0]            drop_cnt_r;
   logic [NUM_SINKS-1:0]   full_s;
   logic [NUM_SINKS-1:0]   empty_s;
   logic [NUM_SINKS-1:0]   we_s;
   logic [ENTRY_W-1:0]     din_s;
   logic [ENTRY_W-1:0]     dout_s [NUM_SINKS];

   assign din_s     = {s_tlast, s_tuser, s_tdata};
   assign s_tready  = ready_s;
   assign dropCount = drop_cnt_r;

   // Destination decode: the head beat routes itself, later beats follow cur_dest_r.
   always_comb begin
      head_dest_s = s_tuser[DEST_LSB +: DEST_W];
      head_ok_s   = ({1'b0, head_dest_s} < SINKS_V);
      sel_dest_s  = (state_r == HEAD) ? head_dest_s : cur_dest_r;
      sel_full_s  = 1'b0;
      for (int i = 0; i < NUM_SINKS; i++) begin
         if (sel_dest_s == DEST_W'(i)) begin
            sel_full_s = full_s[i];
         end else begin
            sel_full_s = sel_full_s;
         end
      end
   end

   // Input ready: only the selected sink's fill level matters, never m_tready.
   always_comb begin
      ready_s = 1'b0;
      if (rst) begin
         ready_s = 1'b0;
      end else begin
         case (state_r)
            HEAD:    ready_s = head_ok_s ? !sel_full_s : 1'b1;
            BODY:    ready_s = !sel_full_s;
            DROP:    ready_s = 1'b1;
            default: ready_s = 1'b0;
         endcase
      end
   end

   assign accept_s = s_tvalid && ready_s;

   // Routing FSM next state plus write/discard decisions for the accepted beat.
   always_comb begin
      state_nxt_s = state_r;
      keep_s      = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         HEAD: begin
            if (accept_s) begin
               if (head_ok_s) begin
                  keep_s      = 1'b1;
                  state_nxt_s = s_tlast ? HEAD : BODY;
               end else begin
                  drop_s      = 1'b1;
                  state_nxt_s = s_tlast ? HEAD : DROP;
               end
            end else begin
               state_nxt_s = HEAD;
            end
         end
         BODY: begin
            if (accept_s) begin
               keep_s      = 1'b1;
               state_nxt_s = s_tlast ? HEAD : BODY;
            end else begin
               state_nxt_s = BODY;
            end
         end
         DROP: begin
            if (accept_s) begin
               state_nxt_s = s_tlast ? HEAD : DROP;
            end else begin
               state_nxt_s = DROP;
            end
         end
         default: state_nxt_s = HEAD;
      endcase
   end

   // Per-sink write enables.
   always_comb begin
      we_s = {NUM_SINKS{1'b0}};
      for (int i = 0; i < NUM_SINKS; i++) begin
         we_s[i] = keep_s && (sel_dest_s == DEST_W'(i));
      end
   end

   // FSM state and latched destination.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= HEAD;
         cur_dest_r <= {DEST_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == HEAD && accept_s && head_ok_s) begin
            cur_dest_r <= head_dest_s;
         end
      end
   end

   // Saturating dropped-packet counter (counted once, on the head beat).
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r <= 16'h0000;
      end else if (drop_s && drop_cnt_r != 16'hFFFF) begin
         drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
   end

   for (genvar i = 0; i < NUM_SINKS; i++) begin : g_sink
      axis_fifo_sc #(
         .aw(AW),
         .dw(ENTRY_W)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .din   (din_s),
         .we    (we_s[i]),
         .full  (full_s[i]),
         .dout  (dout_s[i]),
         .re    (m_tready[i] && !empty_s[i]),
         .empty (empty_s[i])
      );

      assign m_tvalid[i]                            = !empty_s[i];
      assign m_tlast[i]                             = dout_s[i][LAST_BIT];
      assign m_tuser[i*USER_WIDTH +: USER_WIDTH]    = dout_s[i][USER_LSB +: USER_WIDTH];
      assign m_tdata[i*DATA_WIDTH +: DATA_WIDTH]    = dout_s[i][DATA_WIDTH-1:0];
   end

endmodule
